// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_t       : scheduler state encoding
//   WLS_*            : line-control word length encodings (5..8 data bits)
//   FRAME_CYCLES_MAX : longest possible frame in bclk cycles (12 bits x 16x)
//   ctr_width()      : width of the shared gap/watchdog counter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_START,
        ST_WAIT,
        ST_GAP,
        ST_BREAK
    } tx_state_t;

    localparam logic [1:0] WLS_5 = 2'd0;
    localparam logic [1:0] WLS_6 = 2'd1;
    localparam logic [1:0] WLS_7 = 2'd2;
    localparam logic [1:0] WLS_8 = 2'd3;

    localparam int FRAME_BITS_MAX   = 12;
    localparam int OSM_MAX          = 16;
    localparam int FRAME_CYCLES_MAX = FRAME_BITS_MAX * OSM_MAX;

    function automatic int ctr_width(input int gap_cycles, input int timeout_cycles);
        int m;
        m = (gap_cycles > timeout_cycles) ? gap_cycles : timeout_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/uart_cycle_timer.sv
// Saturating up-counter with clear/enable and a terminal-count flag.
// Ports:
//   clk, rst_n : block clock, async active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count one step this cycle
//   limit      : terminal-count compare value
//   tc         : high while count == limit
module uart_cycle_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: pops the TX FIFO, latches line control for the
// frame, launches the shifter, waits for finish under a watchdog, inserts an
// optional inter-frame gap and sequences break. Produces THRE/TEMT.
// Build option: define UART_TX_SCHED_BREAK_EN to include the BREAK state;
// otherwise bc_in is ignored and break_out is tied low.
// Ports:
//   bclk_in, rstn_in           : clock, async active-low reset
//   enable_in, bc_in           : transmitter enable, break request
//   wls_in..osm_sel_in         : live line-control fields
//   fifo_empty_in/data_in/rd_out : show-ahead TX FIFO handshake
//   shift_*_out, shift_finish_in : shifter launch, latched fields, finish
//   break_out, char_done_out, err_out, thre_out, temt_out : status
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for enable and a character (or break)
// POP      | FIFO pop strobe, fields latched at closing edge
// START    | shifter launch pulse visible
// WAIT     | frame in flight, watchdog running
// GAP      | inter-frame idle time
// BREAK    | line forced low while bc_in and enable_in hold
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       bclk_in,
    input  logic       rstn_in,
    input  logic       enable_in,
    input  logic [1:0] wls_in,
    input  logic       stb_in,
    input  logic       pen_in,
    input  logic       esp_in,
    input  logic       sp_in,
    input  logic       osm_sel_in,
    input  logic       bc_in,
    input  logic       fifo_empty_in,
    input  logic [7:0] fifo_data_in,
    output logic       fifo_rd_out,
    output logic       shift_start_out,
    output logic [7:0] shift_data_out,
    output logic [1:0] shift_wls_out,
    output logic       shift_stb_out,
    output logic       shift_pen_out,
    output logic       shift_esp_out,
    output logic       shift_sp_out,
    output logic       shift_osm_out,
    input  logic       shift_finish_in,
    output logic       shift_abort_out,
    output logic       break_out,
    output logic       char_done_out,
    output logic       err_out,
    output logic       thre_out,
    output logic       temt_out
);

    localparam int CW = ctr_width(GAP_CYCLES, TIMEOUT_CYCLES);
    // The watchdog flags one count early so that the registered err/abort
    // pulse appears exactly TIMEOUT_CYCLES cycles after the start pulse.
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT_CYCLES - 2);
    localparam logic [CW-1:0] GAP_LIMIT  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam tx_state_t     AFTER_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES <= FRAME_CYCLES_MAX) begin : g_bad_timeout
        $error("uart_tx_sched: TIMEOUT_CYCLES shorter than the longest frame");
    end

    tx_state_t       state, state_nxt;
    logic            start_nxt, abort_nxt, done_nxt, err_nxt;
    logic            ctr_clr, ctr_en, ctr_tc;
    logic [CW-1:0]   ctr_limit;
    logic            break_req;

`ifdef UART_TX_SCHED_BREAK_EN
    assign break_req = bc_in;
`else
    logic unused_bc;
    assign break_req = 1'b0;
    assign unused_bc = bc_in;
`endif

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        abort_nxt = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        ctr_en    = 1'b0;
        ctr_limit = WAIT_LIMIT;
        case (state)
            ST_IDLE: begin
                if (enable_in) begin
                    if (break_req)           state_nxt = ST_BREAK;
                    else if (!fifo_empty_in) state_nxt = ST_POP;
                end
            end
            ST_POP: begin
                start_nxt = 1'b1;
                state_nxt = ST_START;
            end
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // finish outranks both disable and watchdog expiry
                if (shift_finish_in) begin
                    done_nxt  = 1'b1;
                    state_nxt = AFTER_FRAME;
                end else if (!enable_in) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (ctr_tc) begin
                    err_nxt   = 1'b1;
                    abort_nxt = 1'b1;
                    state_nxt = AFTER_FRAME;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_GAP: begin
                ctr_limit = GAP_LIMIT;
                if (!enable_in || ctr_tc) state_nxt = ST_IDLE;
                else                      ctr_en    = 1'b1;
            end
`ifdef UART_TX_SCHED_BREAK_EN
            ST_BREAK: begin
                if (!bc_in || !enable_in) state_nxt = AFTER_FRAME;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Every state change restarts the shared counter, so both WAIT and GAP
    // begin counting from zero.
    assign ctr_clr = (state_nxt != state);

    uart_cycle_timer #(.WIDTH(CW)) u_timer (
        .clk   (bclk_in),
        .rst_n (rstn_in),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .limit (ctr_limit),
        .tc    (ctr_tc)
    );

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state           <= ST_IDLE;
            shift_start_out <= 1'b0;
            shift_abort_out <= 1'b0;
            char_done_out   <= 1'b0;
            err_out         <= 1'b0;
            shift_data_out  <= '0;
            shift_wls_out   <= '0;
            shift_stb_out   <= 1'b0;
            shift_pen_out   <= 1'b0;
            shift_esp_out   <= 1'b0;
            shift_sp_out    <= 1'b0;
            shift_osm_out   <= 1'b0;
        end else begin
            state           <= state_nxt;
            shift_start_out <= start_nxt;
            shift_abort_out <= abort_nxt;
            char_done_out   <= done_nxt;
            err_out         <= err_nxt;
            if (state == ST_POP) begin
                shift_data_out <= fifo_data_in;
                shift_wls_out  <= wls_in;
                shift_stb_out  <= stb_in;
                shift_pen_out  <= pen_in;
                shift_esp_out  <= esp_in;
                shift_sp_out   <= sp_in;
                shift_osm_out  <= osm_sel_in;
            end
        end
    end

    assign fifo_rd_out = (state == ST_POP);

`ifdef UART_TX_SCHED_BREAK_EN
    assign break_out = (state == ST_BREAK);
`else
    assign break_out = 1'b0;
`endif

    assign thre_out = fifo_empty_in && (state != ST_POP) && (state != ST_START);
    assign temt_out = fifo_empty_in && ((state == ST_IDLE) || (state == ST_BREAK));

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side controller for the UART shift engine. Pops characters from the show-ahead TX FIFO, latches the line-control fields for the duration of each frame, and launches the shifter with a one-cycle start pulse. It then waits for the shifter's finish pulse, with a watchdog, and enforces an optional inter-frame gap. It also sequences break transmission and produces the THRE/TEMT status consumed by the register block.

## Interface
- GAP_CYCLES, 0, idle bclk cycles inserted after each frame before the next pop (0 = back-to-back).
- TIMEOUT_CYCLES, 256, bclk cycles allowed in WAIT before the frame is declared lost; must be ≥ 2.
- bclk_in  input  1  block clock; all state updates on its rising edge.
- rstn_in  input  1  reset, asynchronous, active-low.
- enable_in  input  1  transmitter enable.
- wls_in  input  2  word length select: 0..3 = 5..8 data bits.
- stb_in, pen_in, esp_in, sp_in  input  1 each  stop-bit select, parity enable, even parity, stick parity.
- osm_sel_in  input  1  oversampling select: 1 = 13x, 0 = 16x.
- bc_in  input  1  break control request.
- fifo_empty_in  input  1  TX FIFO empty.
- fifo_data_in  input  8  FIFO head word, valid while !fifo_empty_in.
- fifo_rd_out  output  1  pop strobe.
- shift_start_out  output  1  one-cycle launch pulse to the shifter.
- shift_data_out  output  8  latched character.
- shift_wls_out  output  2  latched wls field.
- shift_stb_out, shift_pen_out, shift_esp_out, shift_sp_out, shift_osm_out  output  1 each  latched line control, stable from POP until the next POP.
- shift_finish_in  input  1  one-cycle pulse from the shifter: stop bit(s) complete.
- shift_abort_out  output  1  one-cycle pulse: the shifter must return to idle and drive the line high.
- break_out  output  1  forces serial line low.
- char_done_out  output  1  one-cycle pulse per completed frame.
- err_out  output  1  one-cycle pulse on watchdog expiry.
- thre_out, temt_out  output  1 each  holding-empty and transmitter-empty status.

## Operation
- State register holds IDLE, POP, START, WAIT, GAP or BREAK. Reset enters IDLE.
- IDLE:
  - !enable_in → stay.
  - Else bc_in → BREAK.
  - Else !fifo_empty_in → POP.
- POP: fifo_rd_out = 1 for exactly this cycle. At the cycle's closing edge, latch fifo_data_in into shift_data_out and wls_in/stb_in/pen_in/esp_in/sp_in/osm_sel_in into the shift_* fields. Then → START.
- START: shift_start_out = 1 for this cycle; clear the watchdog counter; → WAIT.
- WAIT, evaluated in priority order:
  - shift_finish_in → char_done_out pulse next cycle; → GAP if GAP_CYCLES > 0, else IDLE.
  - !enable_in → shift_abort_out pulse; → IDLE; the character is discarded.
  - Watchdog reaches TIMEOUT_CYCLES−1 → err_out pulse and shift_abort_out pulse; → GAP (or IDLE if GAP_CYCLES = 0).
  - Otherwise the watchdog increments.
- GAP: count up to GAP_CYCLES−1, then → IDLE. !enable_in → IDLE immediately.
- BREAK: break_out = 1. Leave when bc_in or enable_in deasserts: → GAP, or IDLE if GAP_CYCLES = 0.
- bc_in is ignored outside IDLE and BREAK. An in-flight frame always completes before break starts.
- thre_out = fifo_empty_in && state ∉ {POP, START}.
- temt_out = fifo_empty_in && state ∈ {IDLE, BREAK}.
- Counter width is $clog2(max(GAP_CYCLES, TIMEOUT_CYCLES)) + 1. The counter saturates and never wraps.

## Timing
- Reset values:
  - All pulse outputs, fifo_rd_out, break_out and shift_* registers are 0.
  - thre_out = temt_out = fifo_empty_in, combinational from the IDLE state.
- Pulse outputs (shift_start_out, shift_abort_out, char_done_out, err_out) are registered; fifo_rd_out and break_out decode the state register.
- Launch latency: FIFO sampled non-empty in IDLE at edge k → fifo_rd_out high in cycle k+1 → shift_start_out high in cycle k+2.
- Back-to-back frames (GAP_CYCLES = 0): shift_finish_in in cycle n → next fifo_rd_out in cycle n+2, next shift_start_out in cycle n+3.
- Simultaneous shift_finish_in with timeout or !enable_in: finish wins. char_done_out pulses; no err_out, no abort.
- Asynchronous reset mid-frame: immediate return to IDLE; no pulses are emitted on reset release.

## Configuration
- UART_TX_SCHED_BREAK_EN defined: BREAK state and bc_in handling are present as described.
- Not defined: bc_in is ignored, the BREAK state is not generated, and break_out is tied to 0.

## Structure
- Shared package uart_pkg holds:
  - the state encoding enum;
  - wls_in encodings for 5/6/7/8 bits;
  - the maximum frame length constant: 12 bits × 16 = 192 cycles, used to sanity-check TIMEOUT_CYCLES.
- One sub-module, uart_cycle_timer: a clear/enable saturating counter with a terminal-count flag, shared by GAP and WAIT.

## Test plan
- FIFO holds 0x55 with wls_in = 3, pen_in = 1, and the shifter model returns finish 120 cycles after start → fifo_rd_out at k+1, shift_start_out at k+2, shift_data_out = 0x55, shift_wls_out = 3, one char_done_out, thre_out/temt_out back to 1.
- Three queued bytes, GAP_CYCLES = 4 → exactly 3 pops; shift_start_out 4 cycles later than the back-to-back case after each finish.
- Change wls_in 3→0 during WAIT → shift_wls_out stays 3 until the next POP.
- Shifter never finishes, TIMEOUT_CYCLES = 256 → err_out and shift_abort_out at cycle 256 after start; the next byte still launches.
- enable_in dropped in WAIT at the same cycle as shift_finish_in → char_done_out only; then dropped alone → shift_abort_out and return to IDLE.
- With UART_TX_SCHED_BREAK_EN defined, bc_in raised mid-frame → break_out rises only after char_done_out and falls 1 cycle after bc_in drops. Without the macro, break_out stays 0.
